// File: rtl/fetch_unit.sv
// Multi-cycle Y86-64 fetch stage: reads instruction bytes over a byte-wide req/ack port
// and decodes icode/ifun/rA/rB/valC/valP. Optional ack timeout under FETCH_TIMEOUT_EN.
module fetch_unit #(
    parameter int unsigned MEM_SIZE       = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] PC_in,
    input  logic        start,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        valid,
    output logic        busy,
    output logic        imem_error,
    output logic        instr_invalid
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

    state_t      state, state_nx;
    logic [63:0] pc;
    logic [3:0]  cnt;
    logic [3:0]  cur_icode;
    logic [3:0]  len;
    logic [3:0]  vsel;
    logic [63:0] addr;
    logic        in_range;
    logic        xfer;
    logic        last;
    logic        timeout;
`ifdef FETCH_TIMEOUT_EN
    logic [31:0] wcnt;
`endif

    // Invalid icodes report length 1 so they finish right after byte 0.
    function automatic logic [3:0] ilen(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: ilen = 4'd2;
            4'h7, 4'h8:             ilen = 4'd9;
            4'h3, 4'h4, 4'h5:       ilen = 4'd10;
            default:                ilen = 4'd1;
        endcase
    endfunction

    always_comb begin
        addr      = pc + {60'd0, cnt};
        in_range  = addr < 64'(MEM_SIZE);
        mem_req   = (state == S_FETCH) && in_range;
        mem_addr  = addr;
        xfer      = mem_req && mem_ack;
        cur_icode = (cnt == 4'd0) ? mem_rdata[7:4] : icode;
        len       = ilen(cur_icode);
        last      = xfer && (cnt == len - 4'd1);
        vsel      = cnt - ((len == 4'd10) ? 4'd2 : 4'd1);
        valid     = (state == S_DONE);
        busy      = (state != S_IDLE);
`ifdef FETCH_TIMEOUT_EN
        timeout   = mem_req && !mem_ack && (wcnt == TIMEOUT_CYCLES - 1);
`else
        timeout   = 1'b0;
`endif
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_FETCH;
            S_FETCH: if (!in_range || timeout || last) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= '0;
            cnt           <= '0;
            icode         <= '0;
            ifun          <= '0;
            rA            <= 4'hF;
            rB            <= 4'hF;
            valC          <= '0;
            valP          <= '0;
            imem_error    <= 1'b0;
            instr_invalid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wcnt          <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    pc            <= PC_in;
                    cnt           <= '0;
                    icode         <= '0;
                    ifun          <= '0;
                    rA            <= 4'hF;
                    rB            <= 4'hF;
                    valC          <= '0;
                    valP          <= '0;
                    imem_error    <= 1'b0;
                    instr_invalid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    wcnt          <= '0;
`endif
                end
                S_FETCH: begin
                    if (!in_range || timeout) begin
                        imem_error <= 1'b1;
                        icode      <= 4'h1;
                        ifun       <= '0;
                        rA         <= 4'hF;
                        rB         <= 4'hF;
                        valC       <= '0;
                        valP       <= pc;
                    end else if (xfer) begin
                        cnt <= cnt + 4'd1;
`ifdef FETCH_TIMEOUT_EN
                        wcnt <= '0;
`endif
                        if (cnt == 4'd0) begin
                            icode <= mem_rdata[7:4];
                            ifun  <= mem_rdata[3:0];
                            if (mem_rdata[7:4] > 4'hB) instr_invalid <= 1'b1;
                        end else if (cnt == 4'd1 && len != 4'd9) begin
                            rA <= mem_rdata[7:4];
                            rB <= mem_rdata[3:0];
                        end else begin
                            valC <= valC | ({56'd0, mem_rdata} << {vsel[2:0], 3'b000});
                        end
                        if (last) valP <= pc + {60'd0, len};
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (mem_req) begin
                        wcnt <= wcnt + 32'd1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a byte memory answers requests with a programmable
// ack delay; expected decode results are queued at start and checked at valid.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] PC_in = '0;
    logic        start = 1'b0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic        valid, busy, imem_error, instr_invalid;

    int total = 0;
    int bad   = 0;
    logic [7:0] mem [0:1023];
    logic stable_ok;

    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic        err, inv;
        int          cyc, xf;
    } exp_t;
    exp_t sbq[$];

    fetch_unit #(.MEM_SIZE(1024), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .PC_in(PC_in), .start(start),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
        .valid(valid), .busy(busy), .imem_error(imem_error), .instr_invalid(instr_invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a fetch at pc, answers each request after dly wait cycles, checks against queue head.
    task automatic run_fetch(input string tag, input logic [63:0] pc, input int dly, input int limit);
        exp_t e;
        int edges, w, xf;
        logic got, waiting;
        logic [63:0] last_addr;
        e = sbq.pop_front();
        @(negedge clk);
        PC_in = pc;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        edges = 0; w = 0; xf = 0; got = 1'b0; waiting = 1'b0; last_addr = '0;
        while (!got && edges < limit) begin
            @(negedge clk);
            if (valid) got = 1'b1;
            else begin
                if (mem_req) begin
                    if (waiting && mem_addr !== last_addr) stable_ok = 1'b0;
                    last_addr = mem_addr;
                    if (w == dly) begin
                        mem_ack = 1'b1;
                        mem_rdata = mem[mem_addr[9:0]];
                        xf++; w = 0; waiting = 1'b0;
                    end else begin
                        mem_ack = 1'b0;
                        w++; waiting = 1'b1;
                    end
                end else mem_ack = 1'b0;
                @(posedge clk);
                #1 mem_ack = 1'b0;
                edges++;
            end
        end
        chk({tag, ".valid_seen"}, 64'(got), 64'd1);
        chk({tag, ".icode"}, 64'(icode), 64'(e.icode));
        chk({tag, ".ifun"}, 64'(ifun), 64'(e.ifun));
        chk({tag, ".rA"}, 64'(rA), 64'(e.ra));
        chk({tag, ".rB"}, 64'(rB), 64'(e.rb));
        chk({tag, ".valC"}, valC, e.valc);
        chk({tag, ".valP"}, valP, e.valp);
        chk({tag, ".imem_error"}, 64'(imem_error), 64'(e.err));
        chk({tag, ".instr_invalid"}, 64'(instr_invalid), 64'(e.inv));
        chk({tag, ".cycle"}, 64'(edges + 1), 64'(e.cyc));
        chk({tag, ".transfers"}, 64'(xf), 64'(e.xf));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        // irmovq at 0x100
        mem[12'h100] = 8'h30; mem[12'h101] = 8'hF0; mem[12'h102] = 8'hEF; mem[12'h103] = 8'hCD;
        mem[12'h104] = 8'hAB; mem[12'h105] = 8'h89; mem[12'h106] = 8'h67; mem[12'h107] = 8'h45;
        mem[12'h108] = 8'h23; mem[12'h109] = 8'h01;
        // OPq at 0x20
        mem[12'h020] = 8'h60; mem[12'h021] = 8'h23;
        // call 0x200 at 0, ret at 9, halt at 0xA
        mem[0] = 8'h80; mem[1] = 8'h00; mem[2] = 8'h02; mem[9] = 8'h90; mem[10] = 8'h00;
        mem[1023] = 8'h50;
        mem[12'h030] = 8'hC0;
        mem[12'h040] = 8'h10;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.valid", 64'(valid), 64'd0);
        chk("reset.mem_req", 64'(mem_req), 64'd0);
        chk("reset.icode", 64'(icode), 64'd0);
        chk("reset.rA", 64'(rA), 64'hF);
        chk("reset.rB", 64'(rB), 64'hF);
        chk("reset.valC", valC, 64'd0);
        chk("reset.valP", valP, 64'd0);
        chk("reset.flags", 64'({imem_error, instr_invalid}), 64'd0);
        reset = 1'b0;

        sbq.push_back('{4'h3, 4'h0, 4'hF, 4'h0, 64'h0123456789ABCDEF, 64'h10A, 1'b0, 1'b0, 11, 10});
        run_fetch("irmovq", 64'h100, 0, 60);

        stable_ok = 1'b1;
        sbq.push_back('{4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 64'h22, 1'b0, 1'b0, 9, 2});
        run_fetch("opq", 64'h20, 3, 60);
        chk("opq.addr_stable", 64'(stable_ok), 64'd1);

        sbq.push_back('{4'h8, 4'h0, 4'hF, 4'hF, 64'h200, 64'h9, 1'b0, 1'b0, 10, 9});
        run_fetch("call", 64'h0, 0, 60);
        sbq.push_back('{4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'hA, 1'b0, 1'b0, 2, 1});
        run_fetch("ret", 64'h9, 0, 60);
        sbq.push_back('{4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'hB, 1'b0, 1'b0, 2, 1});
        run_fetch("halt", 64'hA, 0, 60);

        sbq.push_back('{4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1023, 1'b1, 1'b0, 3, 1});
        run_fetch("oob", 64'd1023, 0, 60);
        sbq.push_back('{4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'h31, 1'b0, 1'b1, 2, 1});
        run_fetch("invalid", 64'h30, 0, 60);

        // reset after 4th ack, with a late ack overlapping and following the reset
        @(negedge clk);
        PC_in = 64'h100;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_ack = 1'b1;
            mem_rdata = mem[mem_addr[9:0]];
            @(posedge clk);
            #1 mem_ack = 1'b0;
        end
        @(negedge clk);
        reset = 1'b1;
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset.mem_req", 64'(mem_req), 64'd0);
        chk("midreset.busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        mem_rdata = 8'h30;
        @(posedge clk);
        #1;
        chk("lateack.busy", 64'(busy), 64'd0);
        chk("lateack.mem_req", 64'(mem_req), 64'd0);
        chk("lateack.icode", 64'(icode), 64'd0);
        mem_ack = 1'b0;
        sbq.push_back('{4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h41, 1'b0, 1'b0, 2, 1});
        run_fetch("restart", 64'h40, 0, 60);

        // reset and start together: reset wins
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        PC_in = 64'h40;
        @(posedge clk);
        #1;
        chk("reset_start.busy", 64'(busy), 64'd0);
        reset = 1'b0;
        start = 1'b0;

`ifdef FETCH_TIMEOUT_EN
        sbq.push_back('{4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h50, 1'b1, 1'b0, 17, 0});
        run_fetch("timeout", 64'h50, 1000, 60);
`else
        @(negedge clk);
        PC_in = 64'h50;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("noack.busy", 64'(busy), 64'd1);
        chk("noack.mem_req", 64'(mem_req), 64'd1);
        chk("noack.mem_addr", mem_addr, 64'h50);
        chk("noack.valid", 64'(valid), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
